// File: rtl/barret_inv_2777_if.sv
// Handshake bundle for the GF(2777) modular-inverse engine: an operand channel
// and a result channel, each with valid/ready.
interface barret_inv_2777_if #(
  parameter int W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_inv;
  logic         out_err;

  modport master (
    output in_valid, in_a, out_ready,
    input  in_ready, out_valid, out_inv, out_err
  );

  modport slave (
    input  in_valid, in_a, out_ready,
    output in_ready, out_valid, out_inv, out_err
  );
endinterface

// File: rtl/barret_inv_2777.sv
// Modular inverse over GF(2777) by Fermat exponentiation a^(Q-2), computed
// left-to-right square-and-multiply through one shared Barrett multiplier.
module barret_inv_2777 #(
  parameter int Q  = 2777,
  parameter int MU = 6041,
  parameter int W  = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  barret_inv_2777_if.slave bus
);
  localparam int P  = 2 * W;
  localparam int IW = $clog2(W);
  localparam logic [W-1:0]  EXP  = W'(Q - 2);
  localparam logic [W-1:0]  Q_W  = W'(Q);
  localparam logic [P-1:0]  Q_P  = P'(Q);
  localparam logic [P-1:0]  MU_P = P'(MU);
  localparam logic [IW-1:0] IDX0 = IW'(W - 2);

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  r_q;
  logic [IW-1:0] idx_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  out_inv_q;
  logic          out_err_q;

  logic [W-1:0]  a_red_s;
  logic [W-1:0]  mul_y_s;
  logic [W-1:0]  mul_res_s;

  // x*y mod Q; qh is kept at full P bits because it can exceed 2^(P-1).
  function automatic logic [W-1:0] modmul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [P-1:0] p;
    logic [P-1:0] qh;
    logic [P-1:0] tq;
    logic [P-1:0] rem;
    logic [W-1:0] qv;
    logic [W-1:0] t;
    p   = P'(x) * P'(y);
    qv  = p[P-1:W];
    qh  = P'(qv) * MU_P;
    t   = qh[P-1:W];
    tq  = P'(t) * Q_P;
    rem = p - tq;
    if (rem >= Q_P) begin
      rem = rem - Q_P;
    end else begin
      rem = rem;
    end
    if (rem >= Q_P) begin
      rem = rem - Q_P;
    end else begin
      rem = rem;
    end
    return rem[W-1:0];
  endfunction

  // Operand pre-reduction and multiplier operand selection.
  always_comb begin
    a_red_s   = '0;
    mul_y_s   = r_q;
    mul_res_s = '0;
    if (bus.in_a >= Q_W) begin
      a_red_s = bus.in_a - Q_W;
    end else begin
      a_red_s = bus.in_a;
    end
    if (state_q == MUL) begin
      mul_y_s = a_q;
    end else begin
      mul_y_s = r_q;
    end
    mul_res_s = modmul(r_q, mul_y_s);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      r_q         <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_inv_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= a_red_s;
            r_q        <= a_red_s;
            idx_q      <= IDX0;
            in_ready_q <= 1'b0;
            state_q    <= SQR;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        SQR: begin
          r_q <= mul_res_s;
          if (EXP[idx_q]) begin
            state_q <= MUL;
          end else if (idx_q == '0) begin
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        MUL: begin
          r_q <= mul_res_s;
          if (idx_q == '0) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q - IW'(1);
            state_q <= SQR;
          end
        end
        DONE: begin
          // First DONE cycle publishes the result; later cycles wait for the sink.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_inv_q   <= r_q;
            out_err_q   <= (a_q == '0);
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inv   = out_inv_q;
  assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_barret_inv_2777.sv
// Directed self-checking bench for barret_inv_2777: known inverses, boundary
// operands, backpressure, mid-operation reset and a full 1..2776 sweep.
module tb_barret_inv_2777;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  barret_inv_2777_if bus ();

  barret_inv_2777 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation; returns edges-to-valid, result, and hold-stability during stall.
  task automatic run_op(input logic [11:0] a, input int stall, output int lat,
                        output logic [11:0] inv, output logic err, output logic stable);
    bus.out_ready = (stall == 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = 12'hABC;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) lat = k;
    end
    inv    = bus.out_inv;
    err    = bus.out_err;
    stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.out_inv !== inv || bus.out_err !== err) stable = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_inv !== 12'd0 || bus.out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: rdy=%b vld=%b inv=%0d err=%b, need 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_inv, bus.out_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic [11:0] a_tab [7]  = '{12'd2, 12'd3, 12'd1, 12'd2776, 12'd2778, 12'd0, 12'd2777};
    logic [11:0] inv_tab [7] = '{12'd1389, 12'd926, 12'd1, 12'd2776, 12'd1, 12'd0, 12'd0};
    logic        err_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int          lat;
    logic [11:0] inv;
    logic        err;
    logic        stable;
    for (int i = 0; i < 7; i++) begin
      run_op(a_tab[i], 0, lat, inv, err, stable);
      checks++;
      if (lat != 19) begin
        failures++;
        $display("FAIL latency a=%0d: got %0d edges, need 19", a_tab[i], lat);
      end
      checks++;
      if (inv !== inv_tab[i] || err !== err_tab[i]) begin
        failures++;
        $display("FAIL result a=%0d: inv=%0d err=%b, need inv=%0d err=%b",
                 a_tab[i], inv, err, inv_tab[i], err_tab[i]);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_inv !== inv_tab[i]) begin
        failures++;
        $display("FAIL one_cycle a=%0d: vld=%b rdy=%b inv=%0d, need 0 1 %0d",
                 a_tab[i], bus.out_valid, bus.in_ready, bus.out_inv, inv_tab[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int          lat;
    logic [11:0] inv;
    logic        bad;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 12'd2;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) lat = k;
    end
    inv = bus.out_inv;
    bad = 1'b0;
    for (int s = 0; s < 10; s++) begin
      bus.in_valid = s[0];
      bus.in_a     = 12'd5;
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_inv !== 12'd1389 || bus.out_err !== 1'b0) bad = 1'b1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (lat != 19 || inv !== 12'd1389 || bad) begin
      failures++;
      $display("FAIL backpressure_hold: lat=%0d inv=%0d unstable=%b, need 19 1389 0", lat, inv, bad);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release: vld=%b rdy=%b, need 0 1", bus.out_valid, bus.in_ready);
    end
    bad = 1'b0;
    for (int s = 0; s < 25; s++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL ignored_pulses: engine started from a pulse seen while busy, got 1 need 0");
    end
  endtask

  task automatic test_reset_mid;
    int          lat;
    logic [11:0] inv;
    logic        err;
    logic        stable;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 12'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_inv !== 12'd0) begin
      failures++;
      $display("FAIL reset_mid: rdy=%b vld=%b inv=%0d, need 1 0 0", bus.in_ready, bus.out_valid, bus.out_inv);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(12'd3, 0, lat, inv, err, stable);
    checks++;
    if (lat != 19 || inv !== 12'd926 || err !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: lat=%0d inv=%0d err=%b, need 19 926 0", lat, inv, err);
    end
  endtask

  task automatic test_sweep;
    int          lat;
    logic [11:0] inv;
    logic        err;
    logic        stable;
    int          stall;
    int          prod;
    for (int a = 1; a <= 2776; a++) begin
      stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(12'(a), stall, lat, inv, err, stable);
      prod = (a * int'(inv)) % 2777;
      checks++;
      if ($isunknown({inv, err}) || prod != 1 || err !== 1'b0) begin
        failures++;
        $display("FAIL sweep_inverse a=%0d: inv=%0d err=%b a*inv mod Q=%0d, need 1 and err 0", a, inv, err, prod);
      end
      checks++;
      if (lat != 19 || !stable) begin
        failures++;
        $display("FAIL sweep_timing a=%0d: lat=%0d stable=%b, need 19 1", a, lat, stable);
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 12'd0;
    bus.out_ready = 1'b1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
